// File: rtl/arm_pkg.sv
// Shared ARM definitions: condition-code encodings and flag bit positions
// within the {N,Z,C,V} flag register.
package arm_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition evaluation of a 4-bit condition field against
// the {N,Z,C,V} flags.
module cond_check
    import arm_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        pass = 1'b1;
        case (cond_t'(cond))
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c & !z;
            COND_LS: pass = !c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z & (n == v);
            COND_LE: pass = z | (n != v);
            default: pass = 1'b1;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// Conditional-execution unit: latches the condition result, owns the flag
// register and gates write enables. Optional macro COND_FLAG_FWD_EN forwards
// same-cycle flag updates into the condition evaluation.
module cond_unit
    import arm_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic [1:0] flag_w,
    input  logic       pcs,
    input  logic       reg_w,
    input  logic       mem_w,
    input  logic       no_write,
    input  logic       next_pc,
    input  logic       cond_latch,
    input  logic       flag_en,
    output logic       pc_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic [3:0] flags,
    output logic       cond_ex
);

    logic       wr_nz;
    logic       wr_cv;
    logic [3:0] flags_nxt;
    logic [3:0] eval_flags;
    logic       pass;

    assign wr_nz = flag_en & cond_ex & flag_w[1];
    assign wr_cv = flag_en & cond_ex & flag_w[0];

    assign flags_nxt[FLAG_N] = wr_nz ? alu_flags[FLAG_N] : flags[FLAG_N];
    assign flags_nxt[FLAG_Z] = wr_nz ? alu_flags[FLAG_Z] : flags[FLAG_Z];
    assign flags_nxt[FLAG_C] = wr_cv ? alu_flags[FLAG_C] : flags[FLAG_C];
    assign flags_nxt[FLAG_V] = wr_cv ? alu_flags[FLAG_V] : flags[FLAG_V];

`ifdef COND_FLAG_FWD_EN
    assign eval_flags = flags_nxt;
`else
    assign eval_flags = flags;
`endif

    cond_check u_cond_check (
        .cond  (cond),
        .flags (eval_flags),
        .pass  (pass)
    );

    // state: flag register and latched condition result
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags   <= 4'b0000;
            cond_ex <= 1'b0;
        end else begin
            flags <= flags_nxt;
            if (cond_latch)
                cond_ex <= pass;
        end
    end

    // cond_ex clears asynchronously in reset, so the gating below also covers it
    assign pc_write  = (pcs & cond_ex) | next_pc;
    assign reg_write = reg_w & cond_ex & !no_write;
    assign mem_write = mem_w & cond_ex;

endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit: table of condition vectors plus directed
// sequences for reset, flag gating, partial writes and same-cycle latch/update.
module tb_cond_unit;

    logic       clk;
    logic       reset;
    logic [3:0] cond;
    logic [3:0] alu_flags;
    logic [1:0] flag_w;
    logic       pcs, reg_w, mem_w, no_write, next_pc, cond_latch, flag_en;
    logic       pc_write, reg_write, mem_write;
    logic [3:0] flags;
    logic       cond_ex;

    int tests;
    int fails;

    cond_unit dut (
        .clk        (clk),
        .reset      (reset),
        .cond       (cond),
        .alu_flags  (alu_flags),
        .flag_w     (flag_w),
        .pcs        (pcs),
        .reg_w      (reg_w),
        .mem_w      (mem_w),
        .no_write   (no_write),
        .next_pc    (next_pc),
        .cond_latch (cond_latch),
        .flag_en    (flag_en),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .mem_write  (mem_write),
        .flags      (flags),
        .cond_ex    (cond_ex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] nzcv;
        logic [3:0] cond;
        logic       exp;
    } vec_t;

    vec_t vecs[32];
    int   nvec;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [3:0] f, input logic [3:0] c, input logic e);
        vecs[nvec].nzcv = f;
        vecs[nvec].cond = c;
        vecs[nvec].exp  = e;
        nvec++;
    endtask

    // Latch AL so cond_ex=1, then write all four flags
    task automatic set_flags(input logic [3:0] v);
        cond = 4'b1110; cond_latch = 1'b1;
        tick();
        cond_latch = 1'b0;
        flag_en = 1'b1; flag_w = 2'b11; alu_flags = v;
        tick();
        flag_en = 1'b0; flag_w = 2'b00; alu_flags = 4'b0000;
    endtask

    task automatic latch(input logic [3:0] c);
        cond = c; cond_latch = 1'b1;
        tick();
        cond_latch = 1'b0;
    endtask

    initial begin
        tests = 0; fails = 0; nvec = 0;
        reset = 1'b0; cond = 4'b0000; alu_flags = 4'b0000; flag_w = 2'b00;
        pcs = 1'b0; reg_w = 1'b0; mem_w = 1'b0; no_write = 1'b0;
        next_pc = 1'b0; cond_latch = 1'b0; flag_en = 1'b0;

        add(4'b0100, 4'b0000, 1'b1); add(4'b0100, 4'b0001, 1'b0);
        add(4'b0100, 4'b1000, 1'b0); add(4'b0100, 4'b1001, 1'b1);
        add(4'b0100, 4'b1100, 1'b0); add(4'b0100, 4'b1101, 1'b1);
        add(4'b0010, 4'b1000, 1'b1); add(4'b0010, 4'b1001, 1'b0);
        add(4'b0010, 4'b0010, 1'b1); add(4'b0010, 4'b0011, 1'b0);
        add(4'b1000, 4'b0100, 1'b1); add(4'b1000, 4'b0101, 1'b0);
        add(4'b1000, 4'b1010, 1'b0); add(4'b1000, 4'b1011, 1'b1);
        add(4'b1000, 4'b1100, 1'b0); add(4'b1000, 4'b1101, 1'b1);
        add(4'b1001, 4'b1010, 1'b1); add(4'b1001, 4'b1011, 1'b0);
        add(4'b1001, 4'b1100, 1'b1); add(4'b1001, 4'b1101, 1'b0);
        add(4'b0001, 4'b0110, 1'b1); add(4'b0001, 4'b0111, 1'b0);
        add(4'b0000, 4'b1110, 1'b1); add(4'b0000, 4'b1111, 1'b1);
        add(4'b0000, 4'b0000, 1'b0); add(4'b0000, 4'b0001, 1'b1);

        // Reset state
        #12;
        check("reset_flags", flags, 4'b0000);
        check("reset_cond_ex", {3'b0, cond_ex}, 4'd0);
        next_pc = 1'b1; pcs = 1'b1; reg_w = 1'b1; mem_w = 1'b1;
        #1;
        check("reset_pc_write", {3'b0, pc_write}, 4'd1);
        check("reset_reg_write", {3'b0, reg_write}, 4'd0);
        check("reset_mem_write", {3'b0, mem_write}, 4'd0);
        next_pc = 1'b0; pcs = 1'b0; reg_w = 1'b0; mem_w = 1'b0;
        #2 reset = 1'b1;
        tick();
        check("post_reset_flags", flags, 4'b0000);

        // AL latch enables pc_write on the following cycle
        pcs = 1'b1;
        check("pre_al_pc_write", {3'b0, pc_write}, 4'd0);
        latch(4'b1110);
        check("al_cond_ex", {3'b0, cond_ex}, 4'd1);
        check("al_pc_write", {3'b0, pc_write}, 4'd1);
        pcs = 1'b0;

        // Condition table
        for (int i = 0; i < nvec; i++) begin
            set_flags(vecs[i].nzcv);
            check($sformatf("vec%0d_flags", i), flags, vecs[i].nzcv);
            latch(vecs[i].cond);
            check($sformatf("vec%0d_cond%b", i, vecs[i].cond), {3'b0, cond_ex}, {3'b0, vecs[i].exp});
        end

        // Gated writes with cond_ex=1
        set_flags(4'b0100);
        latch(4'b0000);
        reg_w = 1'b1; mem_w = 1'b1; no_write = 1'b1;
        #1;
        check("nowrite_reg_write", {3'b0, reg_write}, 4'd0);
        check("pass_mem_write", {3'b0, mem_write}, 4'd1);
        no_write = 1'b0;
        #1;
        check("pass_reg_write", {3'b0, reg_write}, 4'd1);

        // cond_ex=0 blocks flag update and writes
        latch(4'b0001);
        check("ne_cond_ex", {3'b0, cond_ex}, 4'd0);
        flag_en = 1'b1; flag_w = 2'b11; alu_flags = 4'b1111;
        tick();
        flag_en = 1'b0; flag_w = 2'b00;
        check("blocked_flags", flags, 4'b0100);
        check("blocked_reg_write", {3'b0, reg_write}, 4'd0);
        check("blocked_mem_write", {3'b0, mem_write}, 4'd0);
        reg_w = 1'b0; mem_w = 1'b0;

        // Partial write: N,Z only from flags=0000
        set_flags(4'b0000);
        flag_en = 1'b1; flag_w = 2'b10; alu_flags = 4'b1011;
        tick();
        flag_en = 1'b0; flag_w = 2'b00;
        check("nz_only_flags", flags, 4'b1000);
        flag_en = 1'b1; flag_w = 2'b01; alu_flags = 4'b0111;
        tick();
        flag_en = 1'b0; flag_w = 2'b00;
        check("cv_only_flags", flags, 4'b1011);

        // flag_en low blocks update even with cond_ex=1
        flag_w = 2'b11; alu_flags = 4'b0000;
        tick();
        flag_w = 2'b00;
        check("no_en_flags", flags, 4'b1011);

        // Same-cycle latch and Z update
        set_flags(4'b0000);
        cond = 4'b0000; cond_latch = 1'b1;
        flag_en = 1'b1; flag_w = 2'b10; alu_flags = 4'b0100;
        tick();
        cond_latch = 1'b0; flag_en = 1'b0; flag_w = 2'b00;
        check("simul_flags", flags, 4'b0100);
`ifdef COND_FLAG_FWD_EN
        check("simul_cond_ex", {3'b0, cond_ex}, 4'd1);
`else
        check("simul_cond_ex", {3'b0, cond_ex}, 4'd0);
`endif
        latch(4'b0000);
        check("after_simul_cond_ex", {3'b0, cond_ex}, 4'd1);

        // Asynchronous reset mid-cycle
        set_flags(4'b1111);
        check("pre_async_flags", flags, 4'b1111);
        check("pre_async_cond_ex", {3'b0, cond_ex}, 4'd1);
        reg_w = 1'b1; mem_w = 1'b1; pcs = 1'b1; next_pc = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("async_flags", flags, 4'b0000);
        check("async_cond_ex", {3'b0, cond_ex}, 4'd0);
        check("async_pc_write", {3'b0, pc_write}, 4'd0);
        check("async_reg_write", {3'b0, reg_write}, 4'd0);
        check("async_mem_write", {3'b0, mem_write}, 4'd0);
        reg_w = 1'b0; mem_w = 1'b0; pcs = 1'b0;
        #1 reset = 1'b1;
        tick();
        check("rearm_flags", flags, 4'b0000);
        check("rearm_cond_ex", {3'b0, cond_ex}, 4'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
